// File: rtl/ext_unit_pipe_if.sv
// +-----------------------------------------------------------------------------+
// | Module   : ext_unit_pipe_if                                                 |
// | Brief    : Handshake bundle between decode, the extender and execute.       |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface ext_unit_pipe_if #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [15:0]      stat_count;

    // Producer/consumer side
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, stat_count
    );

    // Extender side
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, stat_count
    );
endinterface

`default_nettype wire

// File: rtl/ext_unit_pipe.sv
// +-----------------------------------------------------------------------------+
// | Module   : ext_unit_pipe                                                    |
// | Brief    : Registered zero/sign/upper/branch-offset extender behind a       |
// |            2-entry skid buffer. Optional counter: define EXT_STATS_EN.      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module ext_unit_pipe #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ext_unit_pipe_if.slave     bus
);
    localparam int c_pad = OUT_W - IN_W;

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_ext;
    logic             w_push;
    logic             w_pop;

    logic [1:0]       r_count;
    logic [OUT_W-1:0] r_ent0;
    logic [OUT_W-1:0] r_ent1;

    assign w_sext = {{c_pad{bus.in_data[IN_W-1]}}, bus.in_data};

    always_comb begin
        w_ext = '0;
        case (bus.in_mode)
            2'b00:   w_ext = {{c_pad{1'b0}}, bus.in_data};
            2'b01:   w_ext = w_sext;
            2'b10:   w_ext = {bus.in_data, {c_pad{1'b0}}};
            default: w_ext = {w_sext[OUT_W-3:0], 2'b00};
        endcase
    end

    assign bus.in_ready  = (r_count != 2'd2);
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_data  = r_ent0;

    assign w_push = bus.in_valid & bus.in_ready;
    assign w_pop  = bus.out_valid & bus.out_ready;

    // r_ent0 is always the head; r_ent1 only ever holds the second entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_ent0  <= '0;
            r_ent1  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            if (w_push && ((r_count == 2'd0) || w_pop)) begin
                r_ent0 <= w_ext;
            end else if (w_push) begin
                r_ent1 <= w_ext;
            end else if (w_pop && (r_count == 2'd2)) begin
                r_ent0 <= r_ent1;
            end
        end
    end

`ifdef EXT_STATS_EN
    logic [15:0] r_stat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat <= 16'h0000;
        end else if (w_push && (r_stat != 16'hFFFF)) begin
            r_stat <= r_stat + 16'h0001;
        end
    end

    assign bus.stat_count = r_stat;
`else
    assign bus.stat_count = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ext_unit_pipe.sv
// +-----------------------------------------------------------------------------+
// | Module   : tb_ext_unit_pipe                                                 |
// | Brief    : Self-checking bench: vector table, corner sequences, random run. |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_ext_unit_pipe;
    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    ext_unit_pipe_if #(.IN_W(5),  .OUT_W(32)) b5  ();
    ext_unit_pipe_if #(.IN_W(16), .OUT_W(32)) b16 ();

    ext_unit_pipe #(.IN_W(5),  .OUT_W(32)) u5  (.clk(clk), .rst_n(rst_n), .bus(b5));
    ext_unit_pipe #(.IN_W(16), .OUT_W(32)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    always #5 clk = ~clk;

    typedef struct {
        bit          wide;
        logic [1:0]  mode;
        logic [15:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference extension from arithmetic on the field's numeric value
    function automatic logic [31:0] ext_ref(input int w, input logic [1:0] mode, input logic [15:0] din);
        longint one = 1;
        longint v, s, r;
        v = longint'(din) & ((one << w) - 1);
        s = (v >= (one << (w - 1))) ? v - (one << w) : v;
        case (mode)
            2'd0:    r = v;
            2'd1:    r = s;
            2'd2:    r = v * (one << (32 - w));
            default: r = s * 4;
        endcase
        return r[31:0];
    endfunction

    task automatic idle_inputs();
        b5.in_valid  = 1'b0; b5.in_data  = '0; b5.in_mode  = 2'd0; b5.out_ready  = 1'b1;
        b16.in_valid = 1'b0; b16.in_data = '0; b16.in_mode = 2'd0; b16.out_ready = 1'b1;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] got[$];
    logic [31:0] model_q[$];
    int          model_stat;
    int          budget;
    logic [15:0] rd;
    logic [1:0]  rm;

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 16'h0013, 32'h00000013};
        vecs[1]  = '{1'b0, 2'd1, 16'h0013, 32'hFFFFFFF3};
        vecs[2]  = '{1'b0, 2'd2, 16'h0013, 32'h98000000};
        vecs[3]  = '{1'b0, 2'd3, 16'h0013, 32'hFFFFFFCC};
        vecs[4]  = '{1'b0, 2'd1, 16'h000F, 32'h0000000F};
        vecs[5]  = '{1'b1, 2'd1, 16'h8001, 32'hFFFF8001};
        vecs[6]  = '{1'b1, 2'd2, 16'h8001, 32'h80010000};
        vecs[7]  = '{1'b1, 2'd3, 16'h8001, 32'hFFFE0004};
        vecs[8]  = '{1'b1, 2'd0, 16'h8001, 32'h00008001};
        vecs[9]  = '{1'b1, 2'd3, 16'h7FFF, 32'h0001FFFC};
        vecs[10] = '{1'b1, 2'd2, 16'hFFFF, 32'hFFFF0000};
        vecs[11] = '{1'b1, 2'd3, 16'hFFFF, 32'hFFFFFFFC};

        // Reset held two cycles while a push is being offered
        idle_inputs();
        rst_n = 1'b0;
        b5.in_valid  = 1'b1; b5.in_data  = 5'h1F;
        b16.in_valid = 1'b1; b16.in_data = 16'hABCD;
        repeat (2) @(negedge clk);
        chk("rst_out_valid5",  {31'd0, b5.out_valid},  32'd0);
        chk("rst_in_ready5",   {31'd0, b5.in_ready},   32'd1);
        chk("rst_out_data5",   b5.out_data,            32'd0);
        chk("rst_stat5",       {16'd0, b5.stat_count}, 32'd0);
        chk("rst_out_valid16", {31'd0, b16.out_valid}, 32'd0);
        chk("rst_out_data16",  b16.out_data,           32'd0);
        idle_inputs();
        rst_n = 1'b1;

        // Table: one push per vector, result checked one cycle later
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            b5.in_valid  = !vecs[i].wide; b5.in_data  = vecs[i].din[4:0]; b5.in_mode  = vecs[i].mode;
            b16.in_valid = vecs[i].wide;  b16.in_data = vecs[i].din;      b16.in_mode = vecs[i].mode;
            @(negedge clk);
            if (vecs[i].wide) begin
                chk($sformatf("vec%0d_valid", i), {31'd0, b16.out_valid}, 32'd1);
                chk($sformatf("vec%0d_data", i),  b16.out_data, vecs[i].exp);
            end else begin
                chk($sformatf("vec%0d_valid", i), {31'd0, b5.out_valid}, 32'd1);
                chk($sformatf("vec%0d_data", i),  b5.out_data, vecs[i].exp);
            end
            chk($sformatf("vec%0d_model", i), ext_ref(vecs[i].wide ? 16 : 5, vecs[i].mode, vecs[i].din), vecs[i].exp);
        end
        idle_inputs();
        @(negedge clk);
        chk("drain_valid16", {31'd0, b16.out_valid}, 32'd0);
        chk("drain_hold16",  b16.out_data, 32'hFFFFFFFC);

        // Backpressure: A,B,C with consumer stalled, then released
        b16.out_ready = 1'b0; b16.in_mode = 2'd0;
        b16.in_valid = 1'b1; b16.in_data = 16'h000A;
        @(negedge clk);
        chk("bp_ready_after_a", {31'd0, b16.in_ready}, 32'd1);
        b16.in_data = 16'h000B;
        @(negedge clk);
        chk("bp_ready_after_b", {31'd0, b16.in_ready}, 32'd0);
        b16.in_data = 16'h000C;
        @(negedge clk);
        chk("bp_c_stalled",     {31'd0, b16.in_ready}, 32'd0);
        chk("bp_head_stable",   b16.out_data, 32'h0000000A);
        b16.out_ready = 1'b1;
        got.delete();
        budget = 0;
        while (got.size() < 3 && budget < 20) begin
            if (b16.out_valid) got.push_back(b16.out_data);
            if (b16.in_ready && b16.in_data == 16'h000C) begin
                @(negedge clk);
                b16.in_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
            budget++;
        end
        chk("bp_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("bp_first",  got[0], 32'h0000000A);
            chk("bp_second", got[1], 32'h0000000B);
            chk("bp_third",  got[2], 32'h0000000C);
        end
        idle_inputs();

        // Streaming 100 pushes from a fresh reset
        do_reset(1);
        for (int i = 0; i < 100; i++) begin
            b16.in_valid = 1'b1; b16.in_mode = 2'd0; b16.in_data = 16'(i);
            chk($sformatf("stream_ready%0d", i), {31'd0, b16.in_ready}, 32'd1);
            @(negedge clk);
            chk($sformatf("stream_data%0d", i), b16.out_data, 32'(i));
        end
        b16.in_valid = 1'b0;
        @(negedge clk);
`ifdef EXT_STATS_EN
        chk("stream_stat", {16'd0, b16.stat_count}, 32'd100);
`else
        chk("stream_stat", {16'd0, b16.stat_count}, 32'd0);
`endif

        // Reset with a full buffer and handshakes requested
        b16.out_ready = 1'b0; b16.in_valid = 1'b1; b16.in_data = 16'h1234;
        repeat (2) @(negedge clk);
        chk("full_before_rst", {31'd0, b16.in_ready}, 32'd0);
        rst_n = 1'b0; b16.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; b16.in_valid = 1'b0;
        chk("full_rst_valid", {31'd0, b16.out_valid}, 32'd0);
        chk("full_rst_ready", {31'd0, b16.in_ready},  32'd1);
        chk("full_rst_stat",  {16'd0, b16.stat_count}, 32'd0);

        // Random traffic against a queue model
        model_q.delete();
        model_stat = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            chk("rnd_in_ready",  {31'd0, b16.in_ready},  {31'd0, model_q.size() != 2});
            chk("rnd_out_valid", {31'd0, b16.out_valid}, {31'd0, model_q.size() != 0});
            if (model_q.size() != 0) chk("rnd_out_data", b16.out_data, model_q[0]);
`ifdef EXT_STATS_EN
            chk("rnd_stat", {16'd0, b16.stat_count}, 32'(model_stat));
`else
            chk("rnd_stat", {16'd0, b16.stat_count}, 32'd0);
`endif
            rd = 16'($urandom);
            rm = 2'($urandom_range(0, 3));
            b16.in_valid  = ($urandom_range(0, 3) != 0);
            b16.out_ready = ($urandom_range(0, 2) != 0);
            b16.in_data   = rd;
            b16.in_mode   = rm;
            if (b16.out_ready && model_q.size() != 0) void'(model_q.pop_front());
            if (b16.in_valid && b16.in_ready) begin
                model_q.push_back(ext_ref(16, rm, rd));
                if (model_stat < 65535) model_stat++;
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
